// File: rtl/pll_reset_sequencer.sv
// Sequences rPLL reset, lock qualification and core reset release; all outputs registered.
// Latency: lock edge to STABLE is SYNC_STAGES cycles; no backpressure (free-running control FSM).
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 20,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock_async,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] timeout_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_STABLE    = 2'b10,
    ST_RUN       = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             timeout_q, timeout_d;
  logic [7:0]             relock_q, relock_d;
  logic                   pll_reset_q, pll_reset_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      sync_q      <= '0;
      timeout_q   <= 8'd0;
      relock_q    <= 8'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      timeout_q   <= timeout_d;
      relock_q    <= relock_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    relock_d  = relock_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], pll_lock_async};
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RST;
          if (timeout_q != 8'hFF) timeout_d = timeout_q + 8'd1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they flip on the same edge as state.
  always_comb begin
    pll_reset_d = (state_d == ST_PLL_RST);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  assign pll_reset   = pll_reset_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign timeout_cnt = timeout_q;
  assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed table-driven bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock_async;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] timeout_cnt;
  logic [7:0] relock_cnt;

  int n_vec = 0;
  int n_bad = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .CNT_W         (20),
    .SYNC_STAGES   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_lock_async(pll_lock_async),
    .pll_reset     (pll_reset),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .state         (state),
    .timeout_cnt   (timeout_cnt),
    .relock_cnt    (relock_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       lock;
    int         n;
    logic [1:0] st;
    logic       pr;
    logic       sr;
    logic [7:0] to;
    logic [7:0] rl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst, input logic lock, input int n,
                     input logic [1:0] st, input logic pr, input logic sr,
                     input logic [7:0] to, input logic [7:0] rl);
    vec_t v;
    v.name = name; v.rst = rst; v.lock = lock; v.n = n;
    v.st = st; v.pr = pr; v.sr = sr; v.to = to; v.rl = rl;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic pr,
                       input logic sr, input logic [7:0] to, input logic [7:0] rl);
    logic [21:0] act, exp;
    act = {state, pll_reset, sys_rst_n, ready, timeout_cnt, relock_cnt, 1'b0};
    exp = {st, pr, sr, sr, to, rl, 1'b0};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d pll_reset=%0b sys_rst_n=%0b ready=%0b to=%0d rl=%0d, want state=%0d pll_reset=%0b sys_rst_n=%0b ready=%0b to=%0d rl=%0d",
               name, state, pll_reset, sys_rst_n, ready, timeout_cnt, relock_cnt,
               st, pr, sr, sr, to, rl);
    end
  endtask

  initial begin
    // name, rst, lock, edges, state, pll_reset, sys_rst_n(=ready), timeout, relock
    add("reset",          1, 0,  2, 2'd0, 1, 0, 8'd0, 8'd0);
    add("pllrst_hold",    0, 0,  3, 2'd0, 1, 0, 8'd0, 8'd0);
    add("wait_entry",     0, 0,  1, 2'd1, 0, 0, 8'd0, 8'd0);
    add("wait_last",      0, 0, 31, 2'd1, 0, 0, 8'd0, 8'd0);
    add("timeout1",       0, 0,  1, 2'd0, 1, 0, 8'd1, 8'd0);
    add("pllrst2_hold",   0, 0,  3, 2'd0, 1, 0, 8'd1, 8'd0);
    add("wait2_entry",    0, 0,  1, 2'd1, 0, 0, 8'd1, 8'd0);
    add("lock_edge_k",    0, 1,  1, 2'd1, 0, 0, 8'd1, 8'd0);
    add("lock_edge_k1",   0, 1,  1, 2'd1, 0, 0, 8'd1, 8'd0);
    add("stable_k2",      0, 1,  1, 2'd2, 0, 0, 8'd1, 8'd0);
    add("stable_k9",      0, 1,  7, 2'd2, 0, 0, 8'd1, 8'd0);
    add("run_k10",        0, 1,  1, 2'd3, 0, 1, 8'd1, 8'd0);
    add("run_hold",       0, 1,  5, 2'd3, 0, 1, 8'd1, 8'd0);
    add("drop_j",         0, 0,  1, 2'd3, 0, 1, 8'd1, 8'd0);
    add("drop_j1",        0, 0,  1, 2'd3, 0, 1, 8'd1, 8'd0);
    add("drop_j2",        0, 0,  1, 2'd0, 1, 0, 8'd1, 8'd1);
    add("relock_pllrst",  0, 0,  3, 2'd0, 1, 0, 8'd1, 8'd1);
    add("relock_wait",    0, 0,  1, 2'd1, 0, 0, 8'd1, 8'd1);
    add("acquire",        0, 1,  3, 2'd2, 0, 0, 8'd1, 8'd1);
    add("stable_c3",      0, 1,  2, 2'd2, 0, 0, 8'd1, 8'd1);
    add("glitch_low",     0, 0,  1, 2'd2, 0, 0, 8'd1, 8'd1);
    add("glitch_high",    0, 1,  1, 2'd2, 0, 0, 8'd1, 8'd1);
    add("glitch_seen",    0, 1,  1, 2'd1, 0, 0, 8'd1, 8'd1);
    add("restable",       0, 1,  1, 2'd2, 0, 0, 8'd1, 8'd1);
    add("restable_full",  0, 1,  7, 2'd2, 0, 0, 8'd1, 8'd1);
    add("run_again",      0, 1,  1, 2'd3, 0, 1, 8'd1, 8'd1);
    add("reset_in_run",   1, 1,  1, 2'd0, 1, 0, 8'd0, 8'd0);
    add("pllrst_ign_lock",0, 1,  3, 2'd0, 1, 0, 8'd0, 8'd0);
    add("wait_after_rst", 0, 1,  1, 2'd1, 0, 0, 8'd0, 8'd0);
    add("stable_direct",  0, 1,  1, 2'd2, 0, 0, 8'd0, 8'd0);
    add("stable_more",    0, 1,  2, 2'd2, 0, 0, 8'd0, 8'd0);
    add("reset_in_stable",1, 1,  1, 2'd0, 1, 0, 8'd0, 8'd0);
    add("post_rst_wait",  0, 1,  4, 2'd1, 0, 0, 8'd0, 8'd0);
    add("post_rst_stable",0, 1,  1, 2'd2, 0, 0, 8'd0, 8'd0);
    add("prio_reset",     1, 0,  1, 2'd0, 1, 0, 8'd0, 8'd0);
    add("prio_wait",      0, 0, 33, 2'd1, 0, 0, 8'd0, 8'd0);
    add("prio_lock_sync", 0, 1,  2, 2'd1, 0, 0, 8'd0, 8'd0);
    add("prio_lock_wins", 0, 1,  1, 2'd2, 0, 0, 8'd0, 8'd0);

    reset          = 1'b1;
    pll_lock_async = 1'b0;

    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      pll_lock_async = vecs[i].lock;
      repeat (vecs[i].n) tick();
      check(vecs[i].name, vecs[i].st, vecs[i].pr, vecs[i].sr, vecs[i].to, vecs[i].rl);
    end

    // Timeout saturation: each retry is 4 PLL_RST + 32 WAIT_LOCK cycles.
    reset          = 1'b1;
    pll_lock_async = 1'b0;
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      repeat (36) tick();
      check($sformatf("timeout_sat_%0d", t), 2'd0, 1'b1, 1'b0,
            (t > 255) ? 8'd255 : 8'(t), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
